// File: rtl/add_pkg.sv
// Shared definitions for the pipelined adder library: op encoding,
// stage-count derivation and the WIDTH/SEG legality rule.
package add_pkg;

    // Value of the sub input selecting each operation.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Number of SEG-bit pipeline stages needed for a WIDTH-bit operation.
    function automatic int unsigned calc_nseg(input int unsigned width, input int unsigned seg);
        return (seg == 0) ? 1 : width / seg;
    endfunction

    // A legal configuration splits WIDTH into at least one whole segment.
    function automatic bit seg_legal(input int unsigned width, input int unsigned seg);
        return (seg != 0) && (width >= seg) && ((width % seg) == 0);
    endfunction

endpackage

// File: rtl/add_seg.sv
// Combinational SEG-bit ripple-carry adder built from per-bit full-adder
// equations.
//   a, b : SEG-bit operands
//   cin  : carry into bit 0
//   s    : SEG-bit sum
//   cout : carry out of bit SEG-1
module add_seg #(
    parameter int unsigned SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout
);

    logic [SEG:0] c;

    // Ripple chain: c[i] is the carry into bit i.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < SEG; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (b[i] & c[i]) | (a[i] & c[i]);
        end
    end

    assign cout = c[SEG];

endmodule

// File: rtl/add_pipe.sv
// Pipelined WIDTH-bit adder/subtractor, one SEG-bit segment per stage with
// the carry handed from stage to stage. All stages advance together under
// a single valid/ready handshake; empty stages shift like full ones.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready = !out_valid || out_ready)
//   a, b, cin, sub      : operands; sub=1 computes a-b and ignores cin
//   out_valid/out_ready : result handshake
//   sum, cout, ovf      : registered result, MSB carry (sub: 1 = no borrow),
//                         signed overflow
module add_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    import add_pkg::*;

    localparam int unsigned NSEG = calc_nseg(WIDTH, SEG);
    localparam int unsigned LAST = NSEG - 1;

    if (!seg_legal(WIDTH, SEG)) begin : g_bad_cfg
        $error("add_pipe: WIDTH (%0d) must be a nonzero multiple of SEG (%0d)", WIDTH, SEG);
    end

    logic             adv;

    // Stage inputs: what stage k sees this cycle.
    logic [WIDTH-1:0] st_a   [NSEG];
    logic [WIDTH-1:0] st_b   [NSEG];
    logic [WIDTH-1:0] st_s   [NSEG];
    logic             st_c   [NSEG];
    logic             st_v   [NSEG];

    // Segment adder results and the partial sum they extend.
    logic [SEG-1:0]   seg_s  [NSEG];
    logic             seg_co [NSEG];
    logic [WIDTH-1:0] nx_s   [NSEG];

    // Stage registers.
    logic [WIDTH-1:0] q_a    [NSEG];
    logic [WIDTH-1:0] q_b    [NSEG];
    logic [WIDTH-1:0] q_s    [NSEG];
    logic             q_c    [NSEG];
    logic             q_v    [NSEG];

    logic             ovf_c;
    logic             ovf_q;

    // Whole pipeline moves unless a held result is blocking the output.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        if (k == 0) begin : g_front
            // Subtract as a + ~b + 1.
            assign st_a[k] = a;
            assign st_b[k] = (sub == OP_SUB) ? ~b : b;
            assign st_c[k] = (sub == OP_ADD) ? cin : 1'b1;
            assign st_s[k] = '0;
            assign st_v[k] = in_valid;
        end else begin : g_link
            assign st_a[k] = q_a[k-1];
            assign st_b[k] = q_b[k-1];
            assign st_c[k] = q_c[k-1];
            assign st_s[k] = q_s[k-1];
            assign st_v[k] = q_v[k-1];
        end

        add_seg #(
            .SEG (SEG)
        ) u_seg (
            .a    (st_a[k][k*SEG +: SEG]),
            .b    (st_b[k][k*SEG +: SEG]),
            .cin  (st_c[k]),
            .s    (seg_s[k]),
            .cout (seg_co[k])
        );

        // Bits at and above segment k are still zero in st_s, so OR merges.
        assign nx_s[k] = st_s[k] | (WIDTH'(seg_s[k]) << (k*SEG));

        // Stage register, bubbles included.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q_v[k] <= 1'b0;
                q_c[k] <= 1'b0;
                q_s[k] <= '0;
                q_a[k] <= '0;
                q_b[k] <= '0;
            end else if (adv) begin
                q_v[k] <= st_v[k];
                q_c[k] <= seg_co[k];
                q_s[k] <= nx_s[k];
                q_a[k] <= st_a[k];
                q_b[k] <= st_b[k];
            end
        end
    end

    // Carry into the MSB is recovered as a^b^s at that bit.
    assign ovf_c = st_a[LAST][WIDTH-1] ^ st_b[LAST][WIDTH-1]
                 ^ nx_s[LAST][WIDTH-1] ^ seg_co[LAST];

    // Overflow flag registered alongside the final stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_c;
        end
    end

    assign out_valid = q_v[LAST];
    assign sum       = q_s[LAST];
    assign cout      = q_c[LAST];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_pipe.sv
// Self-checking bench for add_pipe (WIDTH=32, SEG=8): directed corner cases,
// back-pressure, mid-stream reset and a randomized stream scored against an
// arithmetic reference model.
module tb_add_pipe;

    localparam int unsigned W = 32;
    localparam int unsigned S = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_errors = 0;
    int n_pops   = 0;

    logic [33:0]  exp_q [$];
    logic [33:0]  mon_e;

    logic [W-1:0] bp_a [8];
    logic [W-1:0] bp_b [8];
    logic         bp_c [8];
    logic         bp_s [8];

    add_pipe #(
        .WIDTH (W),
        .SEG   (S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from plain unsigned/signed 64-bit arithmetic.
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic op_sub);
        longint ux, uy, sx, sy, ur, sr;
        logic   co, ov;
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (op_sub) begin
            ur = ux - uy;
            sr = sx - sy;
            co = (ux >= uy);
        end else begin
            ur = ux + uy + longint'(ci);
            sr = sx + sy + longint'(ci);
            co = (ur >= 64'sd4294967296);
        end
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {ov, co, ur[31:0]};
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard: decides at the falling edge which transfers the next rising edge performs.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_pops++;
                if (exp_q.size() == 0) begin
                    check("out_spurious", 64'(out_valid), 64'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_sum",  64'(sum),  64'(mon_e[31:0]));
                    check("out_cout", 64'(cout), 64'(mon_e[32]));
                    check("out_ovf",  64'(ovf),  64'(mon_e[33]));
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(a, b, cin, sub));
        end
    end

    // One operation into an idle pipeline; checks latency and the result.
    task automatic send_one(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                            input logic tc, input logic ts,
                            input logic [31:0] es, input logic ec, input logic eo);
        int lat;
        @(posedge clk); #1;
        a = ta; b = tb; cin = tc; sub = ts;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        check({tag, "_lat"},  64'(lat),  64'(4));
        check({tag, "_sum"},  64'(sum),  64'(es));
        check({tag, "_cout"}, 64'(cout), 64'(ec));
        check({tag, "_ovf"},  64'(ovf),  64'(eo));
    endtask

    task automatic drain(input int n);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          idx;
        int          pops0;
        int          stall_left;
        bit          stalled_once;
        bit          took;
        bit          stale;
        logic [31:0] held_sum;
        logic        held_c;
        logic        held_o;

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_sum",       64'(sum),       64'(0));
        check("rst_cout",      64'(cout),      64'(0));
        check("rst_ovf",       64'(ovf),       64'(0));
        check("rst_in_ready",  64'(in_ready),  64'(1));
        rst_n = 1'b1;

        // Directed corners
        send_one("add_ff",   32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        send_one("ripple",   32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        send_one("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        send_one("sub_neg",  32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        send_one("sub_pos",  32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
        send_one("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Back-pressure: 8 back-to-back ops, 3-cycle stall at first result
        for (int i = 0; i < 8; i++) begin
            bp_a[i] = rnd_word(); bp_b[i] = rnd_word();
            bp_c[i] = 1'($urandom_range(0, 1)); bp_s[i] = 1'($urandom_range(0, 1));
        end
        drain(2);
        pops0 = n_pops; idx = 0; took = 1'b0; stall_left = 0; stalled_once = 1'b0;
        held_sum = '0; held_c = 1'b0; held_o = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(posedge clk); #1;
            if (took) idx++;
            in_valid = (idx < 8);
            if (idx < 8) begin
                a = bp_a[idx]; b = bp_b[idx]; cin = bp_c[idx]; sub = bp_s[idx];
            end
            if (out_valid && !stalled_once) begin
                stalled_once = 1'b1;
                stall_left   = 3;
                held_sum = sum; held_c = cout; held_o = ovf;
            end
            out_ready = (stall_left == 0);
            @(negedge clk);
            took = in_valid && in_ready;
            if (stall_left > 0) begin
                check("bp_in_ready",   64'(in_ready),  64'(0));
                check("bp_valid_hold", 64'(out_valid), 64'(1));
                check("bp_sum_hold",   64'({ovf, cout, sum}), 64'({held_o, held_c, held_sum}));
                stall_left--;
            end
            if (n_pops - pops0 >= 8) break;
        end
        drain(6);
        check("bp_delivered", 64'(n_pops - pops0), 64'(8));
        check("bp_queue_empty", 64'(exp_q.size()), 64'(0));

        // Reset with three operations in flight
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'b0;
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_pre_valid", 64'(out_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_sum",   64'(sum),       64'(0));
        check("mid_rst_cout",  64'(cout),      64'(0));
        check("mid_rst_ovf",   64'(ovf),       64'(0));
        check("mid_rst_ready", 64'(in_ready),  64'(1));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        check("mid_no_stale", 64'(stale), 64'(0));
        send_one("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
        drain(2);

        // Random regression with random in_valid / out_ready
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = rnd_word();
            b         = rnd_word();
            cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
        end
        drain(10);
        check("rnd_drained", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
